// File: rtl/lsu_repl_way_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu_repl_way_sel                                              |
// | Description : LFSR-based cache victim way selector with invalid-way        |
// |               priority and lock masking. Optional performance counters     |
// |               are enabled by defining LSU_REPL_PERF_CNT_EN.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lsu_repl_way_sel #(
    parameter int                LFSR_W = 8,
    parameter logic [LFSR_W-1:0] TAPS   = 8'hB8,
    parameter logic [LFSR_W-1:0] SEED   = '1,
    parameter int                NWAYS  = 4,
    parameter int                WAY_W  = $clog2(NWAYS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic              seed_ld,
    input  logic [LFSR_W-1:0] seed,
    input  logic              req,
    input  logic [NWAYS-1:0]  valid_mask,
    input  logic [NWAYS-1:0]  lock_mask,
    output logic              gnt,
    output logic [WAY_W-1:0]  victim,
    output logic              victim_vld,
    output logic [LFSR_W-1:0] lfsr_q,
    output logic [15:0]       perf_rand_cnt,
    output logic [15:0]       perf_inv_cnt
);

    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    logic [LFSR_W-1:0] r_lfsr;
    logic              r_gnt;
    logic [WAY_W-1:0]  r_victim;
    logic              r_victim_vld;

    logic [NWAYS-1:0]  w_elig;
    logic [NWAYS-1:0]  w_inv_cand;
    logic              w_any_inv;
    logic              w_any_elig;
    logic [WAY_W-1:0]  w_inv_way;
    logic [WAY_W-1:0]  w_rand_way;
    logic [WAY_W-1:0]  w_rand_start;
    logic              w_path_inv;
    logic              w_path_rand;
    logic [WAY_W-1:0]  w_sel_way;
    logic              w_step;
    logic              w_feedback;
    logic [LFSR_W-1:0] w_lfsr_nxt;

    assign w_elig       = ~lock_mask;
    assign w_inv_cand   = w_elig & ~valid_mask;
    assign w_any_inv    = |w_inv_cand;
    assign w_any_elig   = |w_elig;
    assign w_rand_start = r_lfsr[WAY_W-1:0];

    // Descending scan so the lowest-index candidate is the last to write.
    always_comb begin
        w_inv_way = '0;
        for (int i = NWAYS - 1; i >= 0; i--) begin
            if (w_inv_cand[i]) begin
                w_inv_way = WAY_W'(i);
            end
        end
    end

    // Upward modulo scan from the LFSR pick; descending order leaves the
    // nearest eligible way (smallest offset) as the final assignment.
    always_comb begin
        logic [WAY_W-1:0] idx;
        w_rand_way = '0;
        idx        = '0;
        for (int i = NWAYS - 1; i >= 0; i--) begin
            idx = w_rand_start + WAY_W'(i);
            if (w_elig[idx]) begin
                w_rand_way = idx;
            end
        end
    end

    assign w_path_inv  = req & w_any_inv;
    assign w_path_rand = req & w_any_elig & ~w_any_inv;

    always_comb begin
        w_sel_way = '0;
        if (w_any_inv) begin
            w_sel_way = w_inv_way;
        end else if (w_any_elig) begin
            w_sel_way = w_rand_way;
        end
    end

    assign w_step     = advance | w_path_rand;
    assign w_feedback = ^(r_lfsr & TAPS);
    assign w_lfsr_nxt = {r_lfsr[LFSR_W-2:0], w_feedback};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else if (seed_ld) begin
            r_lfsr <= (seed == '0) ? SEED : seed;
        end else if (w_step) begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt        <= 1'b0;
            r_victim     <= '0;
            r_victim_vld <= 1'b0;
        end else begin
            r_gnt        <= req;
            r_victim     <= req ? w_sel_way : '0;
            r_victim_vld <= req & w_any_elig;
        end
    end

    // Reset masks a grant already registered from the cycle before it.
    assign gnt        = r_gnt & ~reset;
    assign victim     = reset ? '0 : r_victim;
    assign victim_vld = r_victim_vld & ~reset;
    assign lfsr_q     = r_lfsr;

`ifdef LSU_REPL_PERF_CNT_EN
    logic [15:0] r_rand_cnt;
    logic [15:0] r_inv_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rand_cnt <= '0;
            r_inv_cnt  <= '0;
        end else begin
            if (w_path_rand && (r_rand_cnt != c_cnt_max)) begin
                r_rand_cnt <= r_rand_cnt + 16'd1;
            end
            if (w_path_inv && (r_inv_cnt != c_cnt_max)) begin
                r_inv_cnt <= r_inv_cnt + 16'd1;
            end
        end
    end

    assign perf_rand_cnt = r_rand_cnt;
    assign perf_inv_cnt  = r_inv_cnt;
`else
    logic w_unused_cnt;
    assign w_unused_cnt  = &c_cnt_max;
    assign perf_rand_cnt = '0;
    assign perf_inv_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_repl_way_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lsu_repl_way_sel                                           |
// | Description : Directed self-checking bench for lsu_repl_way_sel (defaults). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lsu_repl_way_sel;

    logic        clk;
    logic        reset;
    logic        advance;
    logic        seed_ld;
    logic [7:0]  seed;
    logic        req;
    logic [3:0]  valid_mask;
    logic [3:0]  lock_mask;
    logic        gnt;
    logic [1:0]  victim;
    logic        victim_vld;
    logic [7:0]  lfsr_q;
    logic [15:0] perf_rand_cnt;
    logic [15:0] perf_inv_cnt;

    int n_cmp;
    int n_err;

    lsu_repl_way_sel dut (
        .clk           (clk),
        .reset         (reset),
        .advance       (advance),
        .seed_ld       (seed_ld),
        .seed          (seed),
        .req           (req),
        .valid_mask    (valid_mask),
        .lock_mask     (lock_mask),
        .gnt           (gnt),
        .victim        (victim),
        .victim_vld    (victim_vld),
        .lfsr_q        (lfsr_q),
        .perf_rand_cnt (perf_rand_cnt),
        .perf_inv_cnt  (perf_inv_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic g, input logic [1:0] v,
                               input logic vv, input logic [7:0] l);
        check({tag, ".gnt"}, 32'(gnt), 32'(g));
        check({tag, ".victim"}, 32'(victim), 32'(v));
        check({tag, ".victim_vld"}, 32'(victim_vld), 32'(vv));
        check({tag, ".lfsr"}, 32'(lfsr_q), 32'(l));
    endtask

    initial begin
        int early;
        int steps;
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        advance    = 1'b0;
        seed_ld    = 1'b0;
        seed       = 8'h00;
        req        = 1'b0;
        valid_mask = 4'h0;
        lock_mask  = 4'h0;
        step();
        step();
        check_grant("reset", 1'b0, 2'd0, 1'b0, 8'hFF);
        check("reset.perf_rand", 32'(perf_rand_cnt), 32'h0);
        check("reset.perf_inv", 32'(perf_inv_cnt), 32'h0);
        reset = 1'b0;

        // Random path twice with req held: FF picks way 3, FE picks way 2.
        req = 1'b1; valid_mask = 4'hF; lock_mask = 4'h0;
        step();
        check_grant("rand1", 1'b1, 2'd3, 1'b1, 8'hFE);
        step();
        check_grant("rand2", 1'b1, 2'd2, 1'b1, 8'hFC);

        // Invalid path: lowest invalid eligible way, no LFSR step.
        valid_mask = 4'b1010;
        step();
        check_grant("inv", 1'b1, 2'd0, 1'b1, 8'hFC);
`ifdef LSU_REPL_PERF_CNT_EN
        check("perf_rand", 32'(perf_rand_cnt), 32'd2);
        check("perf_inv", 32'(perf_inv_cnt), 32'd1);
`else
        check("perf_rand", 32'(perf_rand_cnt), 32'd0);
        check("perf_inv", 32'(perf_inv_cnt), 32'd0);
`endif

        req = 1'b0;
        step();
        check_grant("idle", 1'b0, 2'd0, 1'b0, 8'hFC);

        // Zero seed loads SEED; the load beats advance.
        seed_ld = 1'b1; seed = 8'h00; advance = 1'b1;
        step();
        check("seed0.lfsr", 32'(lfsr_q), 32'h00FF);
        seed_ld = 1'b0; advance = 1'b0;

        // Way 3 locked with LFSR=FF wraps to way 0.
        req = 1'b1; valid_mask = 4'hF; lock_mask = 4'b1000;
        step();
        check_grant("wrap", 1'b1, 2'd0, 1'b1, 8'hFE);

        lock_mask = 4'hF;
        step();
        check_grant("all_locked", 1'b1, 2'd0, 1'b0, 8'hFE);

        // Invalid candidates restricted to eligible ways 2,3.
        valid_mask = 4'h0; lock_mask = 4'b0011;
        step();
        check_grant("inv_locked", 1'b1, 2'd2, 1'b1, 8'hFE);

        // LFSR=FE picks 2, locked, next eligible is 3.
        valid_mask = 4'hF; lock_mask = 4'b0100;
        step();
        check_grant("scan", 1'b1, 2'd3, 1'b1, 8'hFC);

        // req with seed_ld: selection on FC (way 0), load wins, no step.
        lock_mask = 4'h0; seed_ld = 1'b1; seed = 8'h5A;
        step();
        check_grant("req_seed", 1'b1, 2'd0, 1'b1, 8'h5A);
        seed_ld = 1'b0; req = 1'b0;

        advance = 1'b1;
        step();
        check("advance.lfsr", 32'(lfsr_q), 32'h00B4);
        advance = 1'b0;

        // Pending grant dropped by reset in the following cycle.
        req = 1'b1;
        step();
        reset = 1'b1; req = 1'b0;
        #1;
        check_grant("rst_drop", 1'b0, 2'd0, 1'b0, lfsr_q);
        step();
        check_grant("rst_after", 1'b0, 2'd0, 1'b0, 8'hFF);
        reset = 1'b0;
        step();
        check("rst_idle.gnt", 32'(gnt), 32'h0);

        // Maximal-length period.
        advance = 1'b1;
        early = 0;
        steps = 0;
        for (int i = 1; i <= 255; i++) begin
            step();
            steps++;
            if (i < 255 && lfsr_q == 8'hFF) early++;
        end
        advance = 1'b0;
        check("period.early_repeat", 32'(early), 32'd0);
        check("period.lfsr", 32'(lfsr_q), 32'h00FF);
        check("period.steps", 32'(steps), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
